// File: rtl/switch_event_decoder.sv
// Switch-bank reader: synchronizes and debounces the slide switches, then reports
// each settled change against the accepted baseline as one valid/ready event.
module switch_event_decoder #(
    parameter int WIDTH         = 10,
    parameter int STABLE_CYCLES = 2500000,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             enable,
    input  logic             ev_ready,
    output logic             ev_valid,
    output logic [WIDTH-1:0] ev_mask,
    output logic [3:0]       ev_index,
    output logic [3:0]       ev_count,
    output logic             ev_multi,
    output logic [WIDTH-1:0] stable_sw
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        REPORT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sw_s;
    logic [WIDTH-1:0] baseline;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] diff;
    logic [3:0]       diff_low;
    logic [3:0]       diff_pop;
    logic             diff_found;

    // Lowest toggled index and number of toggled switches for the candidate change.
    always_comb begin
        diff       = cand ^ baseline;
        diff_low   = '0;
        diff_pop   = '0;
        diff_found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (diff[i]) begin
                diff_pop = diff_pop + 4'd1;
                if (!diff_found) begin
                    diff_low   = i[3:0];
                    diff_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= sw;
            sw_s      <= sw;
            baseline  <= sw;
            stable_sw <= sw;
            cand      <= sw;
            cnt       <= '0;
            state     <= IDLE;
            ev_valid  <= 1'b0;
            ev_mask   <= '0;
            ev_index  <= '0;
            ev_count  <= '0;
            ev_multi  <= 1'b0;
        end else begin
            sync1 <= sw;
            sw_s  <= sync1;
            case (state)
                IDLE: begin
                    if (enable && (sw_s != baseline)) begin
                        cand  <= sw_s;
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!enable) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (sw_s != cand) begin
                        cand <= sw_s;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // A change that bounced back to the baseline is dropped silently.
                        if (cand == baseline) begin
                            state <= IDLE;
                        end else begin
                            ev_mask   <= diff;
                            ev_index  <= diff_low;
                            ev_count  <= diff_pop;
                            ev_multi  <= (diff_pop > 4'd1);
                            baseline  <= cand;
                            stable_sw <= cand;
                            ev_valid  <= 1'b1;
                            state     <= REPORT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                REPORT: begin
                    if (ev_ready) begin
                        ev_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_event_decoder.sv
// Directed bench for switch_event_decoder with a short stability window.
module tb_switch_event_decoder;

    localparam int W = 10;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw;
    logic         enable;
    logic         ev_ready;
    logic         ev_valid;
    logic [W-1:0] ev_mask;
    logic [3:0]   ev_index;
    logic [3:0]   ev_count;
    logic         ev_multi;
    logic [W-1:0] stable_sw;

    int checks = 0;
    int errors = 0;

    switch_event_decoder #(
        .WIDTH(W),
        .STABLE_CYCLES(S),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .enable(enable),
        .ev_ready(ev_ready),
        .ev_valid(ev_valid),
        .ev_mask(ev_mask),
        .ev_index(ev_index),
        .ev_count(ev_count),
        .ev_multi(ev_multi),
        .stable_sw(stable_sw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges until ev_valid is seen, bounded by limit.
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!ev_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Number of sampled cycles with ev_valid high over a fixed window.
    task automatic quiet(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            tick();
            if (ev_valid) seen++;
        end
    endtask

    task automatic check_event(input string tag, input logic [W-1:0] mask, input logic [3:0] idx,
                               input logic [3:0] cnt, input logic multi, input logic [W-1:0] stable);
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check({tag, "_mask"}, 32'(ev_mask), 32'(mask));
        check({tag, "_index"}, 32'(ev_index), 32'(idx));
        check({tag, "_count"}, 32'(ev_count), 32'(cnt));
        check({tag, "_multi"}, 32'(ev_multi), 32'(multi));
        check({tag, "_stable"}, 32'(stable_sw), 32'(stable));
    endtask

    initial begin
        int n;
        int seen;

        // Reset with a non-zero switch pattern: becomes the baseline, no event.
        sw       = 10'h155;
        reset    = 1'b1;
        enable   = 1'b1;
        ev_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_mask", 32'(ev_mask), 32'd0);
        check("rst_index", 32'(ev_index), 32'd0);
        check("rst_count", 32'(ev_count), 32'd0);
        check("rst_multi", 32'(ev_multi), 32'd0);
        check("rst_stable", 32'(stable_sw), 32'h155);
        quiet(10, seen);
        check("rst_no_event", 32'(seen), 32'd0);

        // Test 1: single switch, latency S+3, hold until accepted.
        sw    = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t1_stable0", 32'(stable_sw), 32'd0);
        sw = 10'b0000100000;
        wait_valid(50, n);
        check("t1_latency", 32'(n), 32'(S + 3));
        check_event("t1", 10'h020, 4'd5, 4'd1, 1'b0, 10'h020);
        repeat (3) tick();
        check("t1_hold", 32'(ev_valid), 32'd1);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("t1_drop", 32'(ev_valid), 32'd0);
        check("t1_mask_kept", 32'(ev_mask), 32'h020);

        // Test 2: bounce on sw[3]; ready held high early must not shortcut the event.
        ev_ready = 1'b1;
        seen     = 0;
        sw       = 10'h028;
        repeat (2) begin tick(); if (ev_valid) seen++; end
        sw = 10'h020;
        repeat (2) begin tick(); if (ev_valid) seen++; end
        sw = 10'h028;
        check("t2_no_early", 32'(seen), 32'd0);
        wait_valid(50, n);
        check("t2_latency", 32'(n), 32'(S + 3));
        check_event("t2", 10'h008, 4'd3, 4'd1, 1'b0, 10'h028);
        tick();
        check("t2_one_cycle", 32'(ev_valid), 32'd0);
        ev_ready = 1'b0;
        quiet(12, seen);
        check("t2_single_event", 32'(seen), 32'd0);

        // Test 3: two-cycle glitch on sw[7] reverts, no event.
        sw = 10'h0A8;
        tick();
        tick();
        sw = 10'h028;
        quiet(15, seen);
        check("t3_no_event", 32'(seen), 32'd0);
        check("t3_stable", 32'(stable_sw), 32'h028);

        // Test 4: simultaneous multi-bit change from zero.
        sw    = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sw    = 10'b1000000011;
        wait_valid(50, n);
        check("t4_latency", 32'(n), 32'(S + 3));
        check_event("t4", 10'h203, 4'd0, 4'd3, 1'b1, 10'h203);

        // Test 5: flip sw[9] while pending; event held, then a second one follows.
        sw = 10'h003;
        repeat (S + 4) tick();
        check_event("t5_held", 10'h203, 4'd0, 4'd3, 1'b1, 10'h203);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("t5_drop", 32'(ev_valid), 32'd0);
        wait_valid(50, n);
        check("t5_latency", 32'(n + 1), 32'(S + 2));
        check_event("t5", 10'h200, 4'd9, 4'd1, 1'b0, 10'h003);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;

        // Test 6a: enable drops mid-window; abort without event.
        sw = 10'h043;
        repeat (4) tick();
        enable = 1'b0;
        tick();
        sw = 10'h003;
        quiet(6, seen);
        enable = 1'b1;
        quiet(12, n);
        check("t6_abort_no_event", 32'(seen + n), 32'd0);
        check("t6_abort_stable", 32'(stable_sw), 32'h003);

        // Test 6b: reset while an event is pending.
        sw = 10'h103;
        wait_valid(50, n);
        check("t6_latency", 32'(n), 32'(S + 3));
        check("t6_pending", 32'(ev_valid), 32'd1);
        sw    = 10'h0F0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_valid", 32'(ev_valid), 32'd0);
        check("t6_rst_mask", 32'(ev_mask), 32'd0);
        check("t6_rst_index", 32'(ev_index), 32'd0);
        check("t6_rst_count", 32'(ev_count), 32'd0);
        check("t6_rst_multi", 32'(ev_multi), 32'd0);
        check("t6_rst_stable", 32'(stable_sw), 32'h0F0);
        quiet(10, seen);
        check("t6_rst_no_event", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
